// File: rtl/usr_reg_pkg.sv
// Shared AXI response codes and read-FSM state encoding for the user register bridge.
package usr_reg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } rd_state_e;

endpackage

// File: rtl/axil_usr_reg_rd_bridge.sv
// AXI4-Lite read front end for the user register space: one outstanding read, fixed read latency.
// Optional macro USR_REG_ADDR_CHECK_EN rejects misaligned/out-of-range addresses with SLVERR.
module axil_usr_reg_rd_bridge
  import usr_reg_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    RD_LATENCY = 3,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = 'h1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  o_usr_reg_rd,
  output logic [ADDR_WIDTH-1:0] o_usr_reg_addr,
  input  logic [DATA_WIDTH-1:0] i_usr_reg_data
);

  localparam int CNT_W = $clog2(RD_LATENCY + 1);

  if (RD_LATENCY < 1) begin : g_bad_latency
    $error("axil_usr_reg_rd_bridge: RD_LATENCY must be >= 1");
  end
  if (ADDR_LIMIT[1:0] != 2'b00) begin : g_unaligned_limit
    $warning("axil_usr_reg_rd_bridge: ADDR_LIMIT is not word aligned");
  end

  rd_state_e             state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
  logic [1:0]            rresp_reg, rresp_next;
  logic                  addr_bad;

`ifdef USR_REG_ADDR_CHECK_EN
  assign addr_bad = (s_axi_araddr[1:0] != 2'b00) || (s_axi_araddr >= ADDR_LIMIT);
`else
  assign addr_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      rdata_reg <= '0;
      rresp_reg <= RESP_OKAY;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      rdata_reg <= rdata_next;
      rresp_reg <= rresp_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    rdata_next = rdata_reg;
    rresp_next = rresp_reg;
    case (state_reg)
      IDLE: begin
        if (s_axi_arvalid) begin
          addr_next = s_axi_araddr;
          if (addr_bad) begin
            rdata_next = '0;
            rresp_next = RESP_SLVERR;
            state_next = RESP;
          end else begin
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_next   = CNT_W'(RD_LATENCY);
        state_next = WAIT;
      end
      WAIT: begin
        cnt_next = cnt_reg - CNT_W'(1);
        // Last wait cycle is exactly RD_LATENCY cycles after the strobe: sample the switch here.
        if (cnt_reg == CNT_W'(1)) begin
          rdata_next = i_usr_reg_data;
          rresp_next = RESP_OKAY;
          state_next = RESP;
        end
      end
      RESP: begin
        if (s_axi_rready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign s_axi_arready  = (state_reg == IDLE);
  assign s_axi_rvalid   = (state_reg == RESP);
  assign o_usr_reg_rd   = (state_reg == ISSUE);
  assign o_usr_reg_addr = addr_reg;
  assign s_axi_rdata    = rdata_reg;
  assign s_axi_rresp    = rresp_reg;

endmodule
